// File: rtl/layer_input_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | layer_input_seq : strided, abortable raster input sequencer for conv      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module layer_input_seq #(
   parameter int IMG_W  = 26,
   parameter int IMG_H  = 26,
   parameter int KERNEL = 3,
   parameter int STRIDE = 1,
   localparam int OUT_W = (IMG_W - KERNEL) / STRIDE + 1,
   localparam int OUT_H = (IMG_H - KERNEL) / STRIDE + 1,
   localparam int WCW   = (OUT_W > 1) ? $clog2(OUT_W) : 1,
   localparam int WRW   = (OUT_H > 1) ? $clog2(OUT_H) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           conv_start,
   input  logic           abort,
   input  logic           pix_valid,
   output logic           busy,
   output logic           fill_ready,
   output logic           win_valid,
   output logic [WRW-1:0] win_row,
   output logic [WCW-1:0] win_col,
   output logic           done
);

   localparam int RW         = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int CW         = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int PW         = (STRIDE > 1) ? $clog2(STRIDE) : 1;
   localparam int FILL_COUNT = IMG_W * (KERNEL - 1) + KERNEL - 1;
   localparam int PCW        = (FILL_COUNT > 0) ? $clog2(FILL_COUNT + 1) : 1;

   localparam logic [RW-1:0]  C_ROW_LAST = RW'(IMG_H - 1);
   localparam logic [CW-1:0]  C_COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0]  C_K1_ROW   = RW'(KERNEL - 1);
   localparam logic [CW-1:0]  C_K1_COL   = CW'(KERNEL - 1);
   localparam logic [PW-1:0]  C_PH_LAST  = PW'(STRIDE - 1);
   localparam logic [PCW-1:0] C_FILL     = PCW'(FILL_COUNT);
   localparam logic [WRW-1:0] C_OR_LAST  = WRW'(OUT_H - 1);
   localparam logic [WCW-1:0] C_OC_LAST  = WCW'(OUT_W - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FILL   = 2'd1,
      S_STREAM = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [RW-1:0]    row_q, row_d;
   logic [CW-1:0]    col_q, col_d;
   logic [PCW-1:0]   pix_cnt_q, pix_cnt_d;
   logic [PW-1:0]    row_ph_q, row_ph_d;
   logic [PW-1:0]    col_ph_q, col_ph_d;
   logic [WRW-1:0]   out_row_q, out_row_d;
   logic [WCW-1:0]   out_col_q, out_col_d;
   logic [WRW-1:0]   win_row_q, win_row_d;
   logic [WCW-1:0]   win_col_q, win_col_d;
   logic             win_valid_q, win_valid_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             fill_ready_q, fill_ready_d;

   logic             row_ge, col_ge;
   logic             row_hit, col_hit;
   logic             accept;
   logic [PCW-1:0]   pix_inc;

   // With a 1x1 kernel every row/column is already past the kernel margin.
   generate
      if (KERNEL == 1) begin : g_k1
         assign row_ge = 1'b1;
         assign col_ge = 1'b1;
      end else begin : g_kn
         assign row_ge = (row_q >= C_K1_ROW);
         assign col_ge = (col_q >= C_K1_COL);
      end
   endgenerate

   assign row_hit = row_ge && (row_ph_q == '0);
   assign col_hit = col_ge && (col_ph_q == '0);
   assign accept  = pix_valid && !abort && (state_q == S_FILL || state_q == S_STREAM);
   assign pix_inc = pix_cnt_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      pix_cnt_d   = pix_cnt_q;
      row_ph_d    = row_ph_q;
      col_ph_d    = col_ph_q;
      out_row_d   = out_row_q;
      out_col_d   = out_col_q;
      win_valid_d = 1'b0;
      win_row_d   = win_row_q;
      win_col_d   = win_col_q;

      case (state_q)
         S_IDLE: begin
            if (conv_start) state_d = (FILL_COUNT == 0) ? S_STREAM : S_FILL;
         end
         S_FILL, S_STREAM: begin
            if (abort)
               state_d = S_IDLE;
            else if (accept && row_q == C_ROW_LAST && col_q == C_COL_LAST)
               state_d = S_DONE;
            else if (accept && state_q == S_FILL && pix_inc == C_FILL)
               state_d = S_STREAM;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         if (row_hit && col_hit) begin
            win_valid_d = 1'b1;
            win_row_d   = out_row_q;
            win_col_d   = out_col_q;
         end
         if (pix_cnt_q != C_FILL) pix_cnt_d = pix_inc;
         if (col_q == C_COL_LAST) begin
            col_d     = '0;
            col_ph_d  = '0;
            out_col_d = '0;
            row_d     = row_q + 1'b1;
            row_ph_d  = !row_ge ? '0 : (row_ph_q == C_PH_LAST) ? '0 : row_ph_q + 1'b1;
            if (row_hit && out_row_q != C_OR_LAST) out_row_d = out_row_q + 1'b1;
         end else begin
            col_d    = col_q + 1'b1;
            col_ph_d = !col_ge ? '0 : (col_ph_q == C_PH_LAST) ? '0 : col_ph_q + 1'b1;
            if (col_hit && out_col_q != C_OC_LAST) out_col_d = out_col_q + 1'b1;
         end
      end

      // Counters only live while a frame is in flight; this also discards an aborted pixel.
      if (state_d != S_FILL && state_d != S_STREAM) begin
         row_d     = '0;
         col_d     = '0;
         pix_cnt_d = '0;
         row_ph_d  = '0;
         col_ph_d  = '0;
         out_row_d = '0;
         out_col_d = '0;
      end

      busy_d       = (state_d == S_FILL) || (state_d == S_STREAM);
      fill_ready_d = (state_d == S_STREAM) || (state_d == S_DONE);
      done_d       = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         row_q        <= '0;
         col_q        <= '0;
         pix_cnt_q    <= '0;
         row_ph_q     <= '0;
         col_ph_q     <= '0;
         out_row_q    <= '0;
         out_col_q    <= '0;
         win_valid_q  <= 1'b0;
         win_row_q    <= '0;
         win_col_q    <= '0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         fill_ready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         col_q        <= col_d;
         pix_cnt_q    <= pix_cnt_d;
         row_ph_q     <= row_ph_d;
         col_ph_q     <= col_ph_d;
         out_row_q    <= out_row_d;
         out_col_q    <= out_col_d;
         win_valid_q  <= win_valid_d;
         win_row_q    <= win_row_d;
         win_col_q    <= win_col_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
         fill_ready_q <= fill_ready_d;
      end
   end

   assign busy       = busy_q;
   assign fill_ready = fill_ready_q;
   assign win_valid  = win_valid_q;
   assign win_row    = win_row_q;
   assign win_col    = win_col_q;
   assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_input_seq.sv
`default_nettype none
// tb_layer_input_seq : three configurations (default, STRIDE=2, 4x4 KERNEL=1)
// checked cycle by cycle against a raster-arithmetic reference model.
module tb_layer_input_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b0;
   logic [2:0] cs = '0, ab = '0, pv = '0;
   logic [2:0] busy, fr, wv, dn;
   logic [4:0] wr0, wc0;
   logic [3:0] wr1, wc1;
   logic [1:0] wr2, wc2;

   int P_W[3] = '{26, 26, 4};
   int P_H[3] = '{26, 26, 4};
   int P_K[3] = '{3, 3, 1};
   int P_S[3] = '{1, 2, 1};

   int errors = 0;
   int checks = 0;
   int last_r[3] = '{0, 0, 0};
   int last_c[3] = '{0, 0, 0};

   layer_input_seq #(.IMG_W(26), .IMG_H(26), .KERNEL(3), .STRIDE(1)) u_d0 (
      .clk(clk), .rst(rst), .conv_start(cs[0]), .abort(ab[0]), .pix_valid(pv[0]),
      .busy(busy[0]), .fill_ready(fr[0]), .win_valid(wv[0]), .win_row(wr0),
      .win_col(wc0), .done(dn[0]));

   layer_input_seq #(.IMG_W(26), .IMG_H(26), .KERNEL(3), .STRIDE(2)) u_d1 (
      .clk(clk), .rst(rst), .conv_start(cs[1]), .abort(ab[1]), .pix_valid(pv[1]),
      .busy(busy[1]), .fill_ready(fr[1]), .win_valid(wv[1]), .win_row(wr1),
      .win_col(wc1), .done(dn[1]));

   layer_input_seq #(.IMG_W(4), .IMG_H(4), .KERNEL(1), .STRIDE(1)) u_d2 (
      .clk(clk), .rst(rst), .conv_start(cs[2]), .abort(ab[2]), .pix_valid(pv[2]),
      .busy(busy[2]), .fill_ready(fr[2]), .win_valid(wv[2]), .win_row(wr2),
      .win_col(wc2), .done(dn[2]));

   function automatic logic [31:0] row_of(input int d);
      case (d)
         0:       return 32'(wr0);
         1:       return 32'(wr1);
         default: return 32'(wr2);
      endcase
   endfunction

   function automatic logic [31:0] col_of(input int d);
      case (d)
         0:       return 32'(wc0);
         1:       return 32'(wc1);
         default: return 32'(wc2);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Pixel n of the raster completes a window when it is the bottom-right corner
   // of a KxK block whose top-left lies on the stride grid.
   function automatic bit qual(input int d, input int n, output int r, output int c);
      int row, col, k1;
      row = n / P_W[d];
      col = n % P_W[d];
      k1  = P_K[d] - 1;
      r   = 0;
      c   = 0;
      if (row < k1 || col < k1) return 1'b0;
      if ((row - k1) % P_S[d] != 0 || (col - k1) % P_S[d] != 0) return 1'b0;
      r = (row - k1) / P_S[d];
      c = (col - k1) / P_S[d];
      return 1'b1;
   endfunction

   task automatic check_all_zero(input string tag, input int d);
      chk({tag, "_busy"}, 32'(busy[d]), 0);
      chk({tag, "_fill"}, 32'(fr[d]), 0);
      chk({tag, "_wv"},   32'(wv[d]), 0);
      chk({tag, "_done"}, 32'(dn[d]), 0);
      chk({tag, "_row"},  row_of(d), 0);
      chk({tag, "_col"},  col_of(d), 0);
   endtask

   // One frame on DUT d. gap = % of idle pix_valid cycles; kill_at = accept count
   // at which abort (use_rst=0) or rst (use_rst=1) hits, -1 for none.
   task automatic run_frame(input int d, input int gap, input int kill_at,
                            input bit use_rst, input bit noise);
      int total, fill, n, cyc, dut_pulses, exp_pulses, er, ec;
      bit acc, kill, q;
      total      = P_W[d] * P_H[d];
      fill       = P_W[d] * (P_K[d] - 1) + P_K[d] - 1;
      exp_pulses = ((P_W[d] - P_K[d]) / P_S[d] + 1) * ((P_H[d] - P_K[d]) / P_S[d] + 1);
      n          = 0;
      cyc        = 0;
      dut_pulses = 0;

      cs[d] = 1'b1;
      @(negedge clk);
      cs[d] = 1'b0;
      chk("start_busy", 32'(busy[d]), 1);
      chk("start_fill", 32'(fr[d]), 32'(fill == 0));
      chk("start_wv",   32'(wv[d]), 0);

      while (n < total) begin
         kill  = (n == kill_at);
         acc   = kill || ($urandom_range(99) >= gap);
         pv[d] = acc;
         ab[d] = kill && !use_rst;
         rst   = kill && use_rst;
         cs[d] = noise ? 1'($urandom_range(1)) : 1'b0;
         @(negedge clk);
         pv[d] = 1'b0;
         ab[d] = 1'b0;
         rst   = 1'b0;
         cs[d] = 1'b0;
         cyc++;
         if (kill) begin
            if (use_rst) begin
               last_r = '{0, 0, 0};
               last_c = '{0, 0, 0};
               check_all_zero("rst_mid", d);
            end else begin
               chk("abort_busy", 32'(busy[d]), 0);
               chk("abort_fill", 32'(fr[d]), 0);
               chk("abort_wv",   32'(wv[d]), 0);
               chk("abort_done", 32'(dn[d]), 0);
               @(negedge clk);
               chk("abort_after_done", 32'(dn[d]), 0);
            end
            return;
         end
         q = 1'b0;
         if (acc) begin
            q = qual(d, n, er, ec);
            if (q) begin
               last_r[d] = er;
               last_c[d] = ec;
            end
            n++;
         end
         dut_pulses += int'(wv[d]);
         chk("win_valid",  32'(wv[d]), 32'(q));
         chk("win_row",    row_of(d), 32'(last_r[d]));
         chk("win_col",    col_of(d), 32'(last_c[d]));
         chk("done",       32'(dn[d]), 32'(n == total));
         chk("busy",       32'(busy[d]), 32'(n != total));
         chk("fill_ready", 32'(fr[d]), 32'(n >= fill));
         if (cyc > 20000) begin
            chk("frame_timeout", 0, 1);
            return;
         end
      end
      chk("pulse_total", 32'(dut_pulses), 32'(exp_pulses));
      @(negedge clk);
      chk("idle_busy", 32'(busy[d]), 0);
      chk("idle_fill", 32'(fr[d]), 0);
      chk("idle_done", 32'(dn[d]), 0);
      chk("idle_wv",   32'(wv[d]), 0);
   endtask

   initial begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int d = 0; d < 3; d++) check_all_zero("reset", d);

      // abort and pix_valid in IDLE must not start anything
      ab[0] = 1'b1;
      pv[0] = 1'b1;
      @(negedge clk);
      ab[0] = 1'b0;
      pv[0] = 1'b0;
      check_all_zero("idle_abort", 0);

      run_frame(0, 0, -1, 1'b0, 1'b0);
      run_frame(0, 50, -1, 1'b0, 1'b1);
      run_frame(0, 0, 100, 1'b0, 1'b0);
      run_frame(0, 0, -1, 1'b0, 1'b0);
      run_frame(0, 0, 300, 1'b1, 1'b0);
      run_frame(0, 0, -1, 1'b0, 1'b1);
      run_frame(1, 0, -1, 1'b0, 1'b0);
      run_frame(1, 30, -1, 1'b0, 1'b0);
      run_frame(2, 0, -1, 1'b0, 1'b0);
      run_frame(2, 50, -1, 1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/layer_input_seq.md
# layer_input_seq

Parametrised input sequencer for a convolution layer. It counts accepted input pixels of an IMG_W x IMG_H feature map, raster order, one pixel per accepted cycle. It reports line-buffer fill status and emits one window-valid pulse, carrying the window's output coordinates, for every KERNEL x KERNEL window completed at the configured STRIDE. It sits between the feature-map source and a convolution engine and replaces the fixed 26x26 / 3x3 input counter with a generic, strided, abortable sequencer.

## Interface
- IMG_W, 26, input feature-map width in pixels (>= KERNEL)
- IMG_H, 26, input feature-map height in pixels (>= KERNEL)
- KERNEL, 3, square kernel size (1..IMG_W)
- STRIDE, 1, window stride in both dimensions (>= 1)
- Derived, not overridable: RW = $clog2(IMG_H), CW = $clog2(IMG_W), OUT_W = (IMG_W-KERNEL)/STRIDE+1, OUT_H = (IMG_H-KERNEL)/STRIDE+1, FILL_COUNT = IMG_W*(KERNEL-1)+KERNEL-1
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- conv_start  in  1  starts a frame; sampled only in IDLE
- abort  in  1  cancels the current frame
- pix_valid  in  1  one input pixel accepted this cycle (accepted only in FILL/STREAM)
- busy  out  1  state is FILL or STREAM
- fill_ready  out  1  line buffers hold enough pixels for the first window
- win_valid  out  1  one-cycle pulse: a window completed on the previous accept
- win_row  out  $clog2(OUT_H)  output row of the pulsed window (min width 1)
- win_col  out  $clog2(OUT_W)  output column of the pulsed window (min width 1)
- done  out  1  one-cycle pulse: last pixel of the frame accepted

## Operation
- States: IDLE, FILL, STREAM, DONE.
- IDLE: all counters 0. conv_start=1 -> FILL. If FILL_COUNT==0 (KERNEL=1), conv_start goes straight to STREAM.
- FILL/STREAM accept: when pix_valid=1, col increments. At col==IMG_W-1, col wraps to 0 and row increments. pix_count increments and saturates at FILL_COUNT.
- FILL -> STREAM on the accept that brings pix_count to FILL_COUNT.
- Window test on each accept at (row, col): row>=KERNEL-1, col>=KERNEL-1, (row-(KERNEL-1)) mod STRIDE==0 and (col-(KERNEL-1)) mod STRIDE==0.
  - Implement the mod tests with row/col phase counters, not dividers. Each phase counter resets to 0 at index KERNEL-1 and wraps at STRIDE-1.
  - Output indices win_row/win_col are counters advanced only on qualifying row/column positions.
- If the test passes, the next cycle gives win_valid=1, win_row = (row-(KERNEL-1))/STRIDE and win_col = (col-(KERNEL-1))/STRIDE.
- Accepting pixel (IMG_H-1, IMG_W-1) -> DONE. DONE lasts one cycle, then returns to IDLE.
- conv_start is ignored outside IDLE. pix_valid is ignored in IDLE and DONE.
- abort=1 in FILL/STREAM -> IDLE next cycle. The abort discards any pixel accepted that cycle: no win_valid, no done. abort has priority over pix_valid.
- abort in IDLE or DONE has no effect. The DONE pulse still occurs.

## Timing
- Reset values: state IDLE; busy, fill_ready, win_valid and done = 0; win_row and win_col = 0; internal counters 0.
- rst overrides everything, including mid-frame. The next cycle is IDLE with all outputs at reset values and no pending pulse.
- busy is registered: it goes high the cycle after conv_start is sampled and low the cycle after the last accept or abort.
- fill_ready is registered:
  - Rises the cycle after the FILL_COUNT-th accept.
  - Stays high through STREAM and DONE.
  - Clears on return to IDLE.
  - With KERNEL=1 it rises together with busy.
- win_valid, win_row and win_col are registered with 1-cycle latency from the completing accept. win_row/win_col hold their last value when win_valid=0.
- done is asserted in the DONE cycle, one cycle after the last accept. It coincides with the win_valid pulse of the final window whenever that window ends on the last pixel.
- Back-to-back frames: conv_start may be high in the cycle after DONE (IDLE). Minimum frame-to-frame gap: 1 IDLE cycle.
- Gaps in pix_valid stall all counters. There is no timeout.
- Totals per frame:
  - win_valid pulses = OUT_W*OUT_H
  - accepts = IMG_W*IMG_H

## Test plan
- Defaults, conv_start then pix_valid held high for 676 cycles:
  - fill_ready rises after the 54th accept.
  - The first win_valid pulse carries (0,0), the last carries (23,23); 576 pulses in total.
  - done is pulsed once, one cycle after the 676th accept, then busy=0.
- STRIDE=2, defaults otherwise:
  - 144 win_valid pulses; win_col runs 0..11.
  - A pulse follows col=2,4,...,24 only on rows 2,4,...,24; no pulse after col 25 or row 25.
- Random pix_valid gaps (~50% duty), defaults: identical sequence of win_row/win_col values as the gapless run; done only after the 676th accept.
- abort after 100 accepts: busy drops next cycle, fill_ready clears, no done. A following conv_start frame restarts from (0,0) with a correct full count.
- rst pulsed mid-STREAM with pix_valid high: next cycle all outputs are 0 and the state is IDLE. conv_start asserted during busy is ignored (pulse count unchanged).
- KERNEL=1, IMG_W=IMG_H=4: fill_ready high with busy; 16 win_valid pulses, one per accept; done after the 16th accept.
